// File: rtl/pipeline_ctrl.sv
// Stall-bus producer: merges ID/EX stall requests, sequences one-cycle flushes,
// and tracks stall statistics with a stuck-stall watchdog.
module pipeline_ctrl #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    input  logic             clr_stats,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [15:0]      MAX_RUN  = 16'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_next;
    logic               w_flush_start;
    logic [5:0]         w_stall;
    logic [15:0]        w_run_next;
    logic               r_flush;
    logic [31:0]        r_new_pc;
    logic [CNT_W-1:0]   r_cycles;
    logic [15:0]        r_run;
    logic               r_timeout;

    // Next-state decode: FLUSH always lasts exactly one cycle; requests there are dropped
    always_comb begin
        w_state_next  = r_state;
        w_flush_start = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush_req) begin
                    w_state_next  = ST_FLUSH;
                    w_flush_start = 1'b1;
                end else begin
                    w_state_next  = ST_RUN;
                end
            end
            ST_FLUSH: w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stall encoding; masked in reset and during FLUSH so flushed slots are not held
    always_comb begin
        w_stall = 6'b000000;
        if (!rst) begin
            w_stall = 6'b000000;
        end else if (r_state != ST_RUN) begin
            w_stall = 6'b000000;
        end else if (stallreq_ex) begin
            w_stall = 6'b001111;
        end else if (stallreq_id) begin
            w_stall = 6'b000111;
        end else begin
            w_stall = 6'b000000;
        end
    end

    // Flush strobe and redirect target, both registered off the flush decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush  <= 1'b0;
            r_new_pc <= 32'h0000_0000;
        end else begin
            r_flush <= w_flush_start;
            if (w_flush_start) begin
                r_new_pc <= flush_pc;
            end else begin
                r_new_pc <= r_new_pc;
            end
        end
    end

    // Consecutive-stall run length, saturating at the watchdog threshold
    always_comb begin
        w_run_next = 16'd0;
        if (!w_stall[0]) begin
            w_run_next = 16'd0;
        end else if (r_run >= MAX_RUN) begin
            w_run_next = MAX_RUN;
        end else begin
            w_run_next = r_run + 16'd1;
        end
    end

    // Statistics; clr_stats wins over any increment in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycles  <= {CNT_W{1'b0}};
            r_run     <= 16'd0;
            r_timeout <= 1'b0;
        end else if (clr_stats) begin
            r_cycles  <= {CNT_W{1'b0}};
            r_run     <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_run <= w_run_next;
            if (w_stall[0] && (r_cycles != CNT_SAT)) begin
                r_cycles <= r_cycles + CNT_ONE;
            end else begin
                r_cycles <= r_cycles;
            end
            if (w_run_next == MAX_RUN) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end
        end
    end

    assign stall         = w_stall;
    assign flush         = r_flush;
    assign new_pc        = r_new_pc;
    assign stall_cycles  = r_cycles;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl (MAX_STALL=4, 4-bit stall counter).
module tb_pipeline_ctrl;

    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 4;

    logic             clk;
    logic             rst;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             flush_req;
    logic [31:0]      flush_pc;
    logic             clr_stats;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cycles;
    logic             stall_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .clr_stats    (clr_stats),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .stall_timeout(stall_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        id;
        logic        ex;
        logic        freq;
        logic [31:0] fpc;
        logic        clr;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_to;
        logic [3:0]  e_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic id, input logic ex, input logic freq, input logic [31:0] fpc,
                       input logic clr, input logic [5:0] e_stall, input logic e_flush,
                       input logic [31:0] e_pc, input logic e_to, input logic [3:0] e_cyc);
        vec_t v;
        v.id = id; v.ex = ex; v.freq = freq; v.fpc = fpc; v.clr = clr;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc; v.e_to = e_to; v.e_cyc = e_cyc;
        vecs.push_back(v);
    endtask

    initial begin
        // inputs: id ex freq fpc clr | expected: stall flush new_pc timeout cycles
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0,   1'b0, 4'd1);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h0,   1'b0, 4'd0);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h0,   1'b0, 4'd1);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h0,   1'b0, 4'd2);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0,   1'b0, 4'd3);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0,   1'b0, 4'd3);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 6'b001111, 1'b0, 32'h0,   1'b0, 4'd3);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h0,   1'b0, 4'd4);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0,   1'b0, 4'd5);
        add(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b0, 4'd5);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b1, 32'h100, 1'b0, 4'd6);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'b001111, 1'b0, 32'h100, 1'b0, 4'd6);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h100, 1'b0, 4'd7);
        add(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 6'b000000, 1'b0, 32'h100, 1'b0, 4'd7);
        add(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 6'b000000, 1'b1, 32'h200, 1'b0, 4'd7);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h200, 1'b0, 4'd7);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h200, 1'b0, 4'd7);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'b001111, 1'b0, 32'h200, 1'b0, 4'd7);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'b001111, 1'b0, 32'h200, 1'b0, 4'd8);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'b001111, 1'b0, 32'h200, 1'b0, 4'd9);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'b001111, 1'b0, 32'h200, 1'b0, 4'd10);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h200, 1'b1, 4'd11);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h200, 1'b1, 4'd11);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h200, 1'b1, 4'd11);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h200, 1'b0, 4'd0);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 6'b001111, 1'b0, 32'h200, 1'b0, 4'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h200, 1'b0, 4'd0);

        rst = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b1;
        flush_req = 1'b0; flush_pc = 32'h0; clr_stats = 1'b0;

        // Reset held with EX stall requested: bus must stay quiet
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall",   32'(stall),         32'h00);
        chk("rst_flush",   32'(flush),         32'h0);
        chk("rst_new_pc",  new_pc,             32'h0);
        chk("rst_cycles",  32'(stall_cycles),  32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);
        rst = 1'b1;
        #1;
        chk("rel_stall", 32'(stall), 32'h0f);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            stallreq_id = vecs[i].id;
            stallreq_ex = vecs[i].ex;
            flush_req   = vecs[i].freq;
            flush_pc    = vecs[i].fpc;
            clr_stats   = vecs[i].clr;
            #3;
            chk($sformatf("v%0d_stall", i),   32'(stall),         32'(vecs[i].e_stall));
            chk($sformatf("v%0d_flush", i),   32'(flush),         32'(vecs[i].e_flush));
            chk($sformatf("v%0d_new_pc", i),  new_pc,             vecs[i].e_pc);
            chk($sformatf("v%0d_timeout", i), 32'(stall_timeout), 32'(vecs[i].e_to));
            chk($sformatf("v%0d_cycles", i),  32'(stall_cycles),  32'(vecs[i].e_cyc));
        end

        // Long EX stall: counter saturates at 4'hf, watchdog trips
        @(posedge clk);
        #1;
        stallreq_id = 1'b0; stallreq_ex = 1'b1; flush_req = 1'b0; clr_stats = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        stallreq_ex = 1'b0;
        #1;
        chk("sat_cycles",  32'(stall_cycles),  32'hf);
        chk("sat_timeout", 32'(stall_timeout), 32'h1);

        // Reset asserted while FLUSH is active
        @(posedge clk);
        #1;
        flush_req = 1'b1; flush_pc = 32'hdead_beef; stallreq_ex = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        chk("pre_rst_flush",  32'(flush), 32'h1);
        chk("pre_rst_new_pc", new_pc,     32'hdead_beef);
        rst = 1'b0;
        #1;
        chk("mid_rst_flush",   32'(flush),         32'h0);
        chk("mid_rst_new_pc",  new_pc,             32'h0);
        chk("mid_rst_stall",   32'(stall),         32'h00);
        chk("mid_rst_timeout", 32'(stall_timeout), 32'h0);
        rst = 1'b1;
        #1;
        chk("post_rst_stall", 32'(stall), 32'h0f);
        @(posedge clk);
        #1;
        chk("post_rst_flush", 32'(flush), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
